// File: rtl/vc_link_tx.sv
// Virtual-channel link transmitter: credit-gated round-robin arbitration with wormhole packet locking.
// Optional protocol/credit error pulse enabled by defining VC_TX_ERR_CHK_EN.
module vc_link_tx #(
    parameter int NUM_VC     = 4,
    parameter int FLIT_W     = 64,
    parameter int MAX_CREDIT = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_VC-1:0]          vc_empty,
    input  logic [NUM_VC*FLIT_W-1:0]   vc_data,
    output logic [NUM_VC-1:0]          vc_read_en,
    output logic                       tx_valid,
    output logic [$clog2(NUM_VC)-1:0]  tx_vc,
    output logic [FLIT_W-1:0]          tx_flit,
    input  logic                       credit_valid,
    input  logic [$clog2(NUM_VC)-1:0]  credit_vc,
    output logic                       error
);

    localparam int VC_W  = $clog2(NUM_VC);
    localparam int CNT_W = $clog2(MAX_CREDIT + 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_CREDIT);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    state_t            state_q, state_d;
    logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
    logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  credit_q [NUM_VC];
    logic [CNT_W-1:0]  credit_d [NUM_VC];
    logic              tx_valid_q, tx_valid_d;
    logic [VC_W-1:0]   tx_vc_q, tx_vc_d;
    logic [FLIT_W-1:0] tx_flit_q, tx_flit_d;

    logic [NUM_VC-1:0] elig;
    logic              grant_any;
    logic [VC_W-1:0]   grant_vc;
    logic [FLIT_W-1:0] grant_flit;
    flit_type_t        grant_type;

    always_comb begin
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            elig[i] = !vc_empty[i] && (credit_q[i] != '0);
        end
    end

    // Locked mode serves only the packet owner; idle mode scans upward from rr_ptr with wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_vc  = '0;
        if (state_q == LOCKED) begin
            if (elig[lock_vc_q]) begin
                grant_any = 1'b1;
                grant_vc  = lock_vc_q;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_VC; k++) begin
                if (!grant_any && elig[rr_ptr_q + VC_W'(k)]) begin
                    grant_any = 1'b1;
                    grant_vc  = rr_ptr_q + VC_W'(k);
                end
            end
        end
    end

    assign grant_flit = vc_data[grant_vc*FLIT_W +: FLIT_W];
    assign grant_type = flit_type_t'(grant_flit[FLIT_W-1 -: 2]);

    always_comb begin
        vc_read_en = '0;
        if (grant_any && reset_n) begin
            vc_read_en[grant_vc] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant_any) begin
            if (state_q == IDLE) begin
                rr_ptr_d = grant_vc + VC_W'(1);
                if (grant_type == FT_HEAD) begin
                    state_d   = LOCKED;
                    lock_vc_d = grant_vc;
                end
            end else if (grant_type == FT_TAIL) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        tx_valid_d = grant_any;
        tx_vc_d    = tx_vc_q;
        tx_flit_d  = tx_flit_q;
        if (grant_any) begin
            tx_vc_d   = grant_vc;
            tx_flit_d = grant_flit;
        end
    end

    // A simultaneous return and grant on one VC cancel, even at a full counter.
    always_comb begin
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            credit_d[i] = credit_q[i];
            if (credit_valid && (credit_vc == VC_W'(i)) && !(grant_any && (grant_vc == VC_W'(i)))) begin
                if (credit_q[i] != CREDIT_MAX) begin
                    credit_d[i] = credit_q[i] + CNT_W'(1);
                end
            end else if (grant_any && (grant_vc == VC_W'(i)) && !(credit_valid && (credit_vc == VC_W'(i)))) begin
                credit_d[i] = credit_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lock_vc_q  <= '0;
            rr_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_vc_q    <= '0;
            tx_flit_q  <= '0;
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                credit_q[i] <= CREDIT_MAX;
            end
        end else begin
            state_q    <= state_d;
            lock_vc_q  <= lock_vc_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_vc_q    <= tx_vc_d;
            tx_flit_q  <= tx_flit_d;
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_vc    = tx_vc_q;
    assign tx_flit  = tx_flit_q;

`ifdef VC_TX_ERR_CHK_EN
    logic error_q, error_d;

    // Only a return that is actually dropped counts; one cancelled by a same-VC grant is legal.
    always_comb begin
        error_d = 1'b0;
        if (credit_valid && (credit_q[credit_vc] == CREDIT_MAX) &&
            !(grant_any && (grant_vc == credit_vc))) begin
            error_d = 1'b1;
        end
        if ((state_q == IDLE) && grant_any &&
            ((grant_type == FT_BODY) || (grant_type == FT_TAIL))) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_vc_link_tx.sv
// Scoreboard bench for vc_link_tx: random packet/credit traffic checked against a queue-based reference model.
module tb_vc_link_tx;

    localparam int NUM_VC     = 4;
    localparam int FLIT_W     = 64;
    localparam int MAX_CREDIT = 32;
    localparam int VC_W       = 2;

    logic                     clk;
    logic                     reset_n;
    logic [NUM_VC-1:0]        vc_empty;
    logic [NUM_VC*FLIT_W-1:0] vc_data;
    logic [NUM_VC-1:0]        vc_read_en;
    logic                     tx_valid;
    logic [VC_W-1:0]          tx_vc;
    logic [FLIT_W-1:0]        tx_flit;
    logic                     credit_valid;
    logic [VC_W-1:0]          credit_vc;
    logic                     error;

    vc_link_tx #(
        .NUM_VC    (NUM_VC),
        .FLIT_W    (FLIT_W),
        .MAX_CREDIT(MAX_CREDIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vc_empty    (vc_empty),
        .vc_data     (vc_data),
        .vc_read_en  (vc_read_en),
        .tx_valid    (tx_valid),
        .tx_vc       (tx_vc),
        .tx_flit     (tx_flit),
        .credit_valid(credit_valid),
        .credit_vc   (credit_vc),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic [VC_W-1:0]   vc;
        logic [FLIT_W-1:0] flit;
        logic              err;
    } exp_t;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    exp_t        sb[$];

    // Reference model: upstream buffers as queues, credits as plain integers.
    logic [FLIT_W-1:0] vq[NUM_VC][$];
    int                m_credit[NUM_VC];
    bit                m_locked;
    int                m_lock_vc;
    int                m_rr;
    logic [VC_W-1:0]   m_last_vc;
    logic [FLIT_W-1:0] m_last_flit;
    int                pend_pop;
    int unsigned       vc_cnt[NUM_VC];

    task automatic chk(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t);
        logic [FLIT_W-1:0] r;
        r = {$urandom(), $urandom()};
        r[FLIT_W-1 -: 2] = t;
        return r;
    endfunction

    task automatic push_pkt(input int vc, input int nbody);
        if (nbody < 0) begin
            vq[vc].push_back(mk(2'b11));
        end else begin
            vq[vc].push_back(mk(2'b01));
            for (int b = 0; b < nbody; b++) vq[vc].push_back(mk(2'b00));
            vq[vc].push_back(mk(2'b10));
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_VC; i++) begin
            vc_empty[i] = (vq[i].size() == 0);
            vc_data[i*FLIT_W +: FLIT_W] = (vq[i].size() > 0) ? vq[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_VC; i++) begin
            m_credit[i] = MAX_CREDIT;
            vq[i].delete();
        end
        m_locked    = 1'b0;
        m_lock_vc   = 0;
        m_rr        = 0;
        m_last_vc   = '0;
        m_last_flit = '0;
        pend_pop    = -1;
    endtask

    task automatic step(input bit cv, input int cvc);
        int                g;
        bit                was_locked;
        logic [1:0]        t;
        logic [FLIT_W-1:0] f;
        logic [NUM_VC-1:0] exp_re;
        exp_t              e;
        @(posedge clk);
        #1;
        if (pend_pop >= 0) void'(vq[pend_pop].pop_front());
        credit_valid = cv;
        credit_vc    = VC_W'(cvc);
        drive_inputs();
        #1;
        g = -1;
        if (m_locked) begin
            if (vq[m_lock_vc].size() > 0 && m_credit[m_lock_vc] > 0) g = m_lock_vc;
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                int v;
                v = (m_rr + k) % NUM_VC;
                if (g < 0 && vq[v].size() > 0 && m_credit[v] > 0) g = v;
            end
        end
        exp_re = '0;
        if (g >= 0) exp_re[g] = 1'b1;
        chk("vc_read_en", FLIT_W'(vc_read_en), FLIT_W'(exp_re));
        e.err      = 1'b0;
        was_locked = m_locked;
        if (g >= 0) begin
            f = vq[g][0];
            t = f[FLIT_W-1 -: 2];
            m_last_vc   = VC_W'(g);
            m_last_flit = f;
            m_credit[g]--;
            if (!was_locked) begin
                m_rr = (g + 1) % NUM_VC;
                if (t == 2'b01) begin
                    m_locked  = 1'b1;
                    m_lock_vc = g;
                end
`ifdef VC_TX_ERR_CHK_EN
                if (t == 2'b00 || t == 2'b10) e.err = 1'b1;
`endif
            end else if (t == 2'b10) begin
                m_locked = 1'b0;
            end
        end
        if (cv) begin
`ifdef VC_TX_ERR_CHK_EN
            if (m_credit[cvc] == MAX_CREDIT) e.err = 1'b1;
`endif
            if (m_credit[cvc] < MAX_CREDIT) m_credit[cvc]++;
        end
        e.v    = (g >= 0);
        e.vc   = m_last_vc;
        e.flit = m_last_flit;
        sb.push_back(e);
        pend_pop = g;
    endtask

    task automatic do_reset(input bit chk_async);
        reset_n      = 1'b0;
        sb.delete();
        credit_valid = 1'b0;
        credit_vc    = '0;
        vc_empty     = '0;
        vc_data      = {NUM_VC{mk(2'b11)}};
        #1;
        if (chk_async) chk("async_tx_valid", FLIT_W'(tx_valid), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read_en", FLIT_W'(vc_read_en), '0);
        chk("rst_tx_valid", FLIT_W'(tx_valid), '0);
        chk("rst_tx_vc", FLIT_W'(tx_vc), '0);
        chk("rst_tx_flit", tx_flit, '0);
        chk("rst_error", FLIT_W'(error), '0);
        model_reset();
        drive_inputs();
        reset_n = 1'b1;
    endtask

    // Monitor: pops one expectation per clock and counts flits actually sent.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n === 1'b1) begin
                if (tx_valid === 1'b1) vc_cnt[tx_vc]++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("tx_valid", FLIT_W'(tx_valid), FLIT_W'(e.v));
                    chk("tx_vc", FLIT_W'(tx_vc), FLIT_W'(e.vc));
                    chk("tx_flit", tx_flit, e.flit);
                    chk("error", FLIT_W'(error), FLIT_W'(e.err));
                end
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        credit_valid = 1'b0;
        credit_vc    = '0;
        vc_empty     = '1;
        vc_data      = '0;
        for (int i = 0; i < NUM_VC; i++) vc_cnt[i] = 0;
        model_reset();
        do_reset(1'b0);

        // Single flit on VC0 right after reset.
        vq[0].push_back(64'hC000_0000_0000_00AA);
        repeat (3) step(1'b0, 0);

        // All VCs backlogged with singles: strict rotation.
        do_reset(1'b1);
        for (int i = 0; i < NUM_VC; i++)
            for (int n = 0; n < 6; n++) push_pkt(i, -1);
        repeat (28) step(1'b0, 0);

        // Packet on VC1 must finish before VC2 singles.
        do_reset(1'b1);
        push_pkt(1, 1);
        for (int n = 0; n < 3; n++) push_pkt(2, -1);
        repeat (10) step(1'b0, 0);

        // Credit exhaustion on VC3, then one returned credit releases exactly one flit.
        do_reset(1'b1);
        for (int n = 0; n < 40; n++) push_pkt(3, -1);
        for (int i = 0; i < NUM_VC; i++) vc_cnt[i] = 0;
        repeat (40) step(1'b0, 0);
        chk("vc3_flits_no_credit", FLIT_W'(vc_cnt[3]), FLIT_W'(MAX_CREDIT));
        step(1'b1, 3);
        repeat (4) step(1'b0, 0);
        chk("vc3_flits_one_credit", FLIT_W'(vc_cnt[3]), FLIT_W'(MAX_CREDIT + 1));

        // Random packets and credit returns, with a reset dropped in mid-run.
        do_reset(1'b1);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (vq[i].size() < 3 && $urandom_range(3, 0) == 0)
                    push_pkt(i, int'($urandom_range(3, 0)) - 1);
                if ($urandom_range(59, 0) == 0)
                    vq[i].push_back(mk(2'b00));
            end
            step($urandom_range(99, 0) < 35, int'($urandom_range(NUM_VC - 1, 0)));
            if (c == 1500) do_reset(1'b1);
        end
        repeat (2) step(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
